// File: rtl/addsub_pkg.sv
// Shared mode encodings, stage-count helper and per-stage control payload for pipelined_addsub.
// Latency: none (declarations only).
// Backpressure: none (declarations only); SATURATE_EN adds the operand sign bit to the payload.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  // One lookahead block is resolved per stage, so depth is the block count.
  function automatic int calc_nstage(input int width, input int block);
    return width / block;
  endfunction

  // Control bits that travel with a beat. The operand remainders and partial sum are
  // WIDTH-dependent and sit next to this struct inside the top-level stage payload.
  typedef struct packed {
    logic carry;   // carry out of the block resolved by this stage
    logic cmsb;    // carry into the top bit of that block (used for overflow at the last stage)
`ifdef SATURATE_EN
    logic a_msb;   // sign of operand a, picks the clamp direction
`endif
  } stage_ctl_t;

endpackage

// File: rtl/pipelined_addsub_cla.sv
// Combinational carry-lookahead block: BLOCK-bit sum from generate/propagate terms.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the enclosing stage register does all holding.
module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat OR of generate terms gated by propagate chains, not a ripple.
  always_comb begin
    logic cc;
    logic chain;
    c     = '0;
    cc    = 1'b0;
    chain = 1'b0;
    c[0]  = cin;
    for (int i = 0; i < BLOCK; i++) begin
      cc    = g[i];
      chain = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc    = cc | (chain & g[j]);
        chain = chain & p[j];
      end
      cc     = cc | (chain & cin);
      c[i+1] = cc;
    end
  end

  assign sum  = p ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
  assign cmsb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined carry-lookahead add/sub, one BLOCK-bit lookahead per stage; SATURATE_EN clamps on overflow.
// Latency: NSTAGE = WIDTH/BLOCK cycles from accept edge to registered result.
// Backpressure: single global enable (out_ready | !out_valid); a stall freezes every stage, bubbles kept.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of
);

  localparam int NSTAGE = calc_nstage(WIDTH, BLOCK);

  if ((WIDTH % BLOCK) != 0) begin : g_width_check
    $error("pipelined_addsub: WIDTH must be a multiple of BLOCK");
  end

  // Skewed operand remainders (already shifted so the next block sits at bit 0),
  // deskewed partial sum, and the per-beat control bits.
  typedef struct packed {
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] psum;
    stage_ctl_t       ctl;
  } stage_t;

  stage_t stage_q [NSTAGE];
  logic   vld_q   [NSTAGE];
  logic   en;

  assign out_valid = vld_q[NSTAGE-1];
  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic             v_in;
    logic [BLOCK-1:0] blk_sum;
    logic             blk_cout;
    logic             blk_cmsb;
    stage_t           nxt;
`ifdef SATURATE_EN
    logic             msb_in;
`endif

    if (k == 0) begin : g_head
      // Subtraction is folded in here once: invert b and the borrow so later stages only add.
      assign a_in = a;
      assign b_in = (mode == MODE_SUB) ? ~b : b;
      assign c_in = (mode == MODE_ADD) ? cin : ~cin;
      assign s_in = '0;
      assign v_in = in_valid;
`ifdef SATURATE_EN
      assign msb_in = a[WIDTH-1];
`endif
    end else begin : g_body
      assign a_in = stage_q[k-1].a_rem;
      assign b_in = stage_q[k-1].b_rem;
      assign c_in = stage_q[k-1].ctl.carry;
      assign s_in = stage_q[k-1].psum;
      assign v_in = vld_q[k-1];
`ifdef SATURATE_EN
      assign msb_in = stage_q[k-1].ctl.a_msb;
`endif
    end

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a    (a_in[BLOCK-1:0]),
      .b    (b_in[BLOCK-1:0]),
      .cin  (c_in),
      .sum  (blk_sum),
      .cout (blk_cout),
      .cmsb (blk_cmsb)
    );

    // Consume the low block, shift the remainders down and drop the result block into place.
    always_comb begin
      nxt                        = '0;
      nxt.a_rem                  = a_in >> BLOCK;
      nxt.b_rem                  = b_in >> BLOCK;
      nxt.psum                   = s_in;
      nxt.psum[k*BLOCK +: BLOCK] = blk_sum;
      nxt.ctl.carry              = blk_cout;
      nxt.ctl.cmsb               = blk_cmsb;
`ifdef SATURATE_EN
      nxt.ctl.a_msb              = msb_in;
`endif
    end

    // Stage register: moves only on the global enable so a stall holds data and valid together.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q[k]   <= 1'b0;
        stage_q[k] <= '0;
      end else if (en) begin
        vld_q[k]   <= v_in;
        stage_q[k] <= nxt;
      end
    end
  end

  assign cout = stage_q[NSTAGE-1].ctl.carry;
  assign of   = stage_q[NSTAGE-1].ctl.carry ^ stage_q[NSTAGE-1].ctl.cmsb;

`ifdef SATURATE_EN
  // On overflow clamp toward the sign of a; both operands share it when overflow is possible.
  always_comb begin
    sum = stage_q[NSTAGE-1].psum;
    if (of) begin
      sum = stage_q[NSTAGE-1].ctl.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum = stage_q[NSTAGE-1].psum;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: 16/4 (four stages) and 16/16 (one stage) side by side.
// Latency: reference pipelines model the accept-to-output delay of each build.
// Backpressure: out_ready is stalled and randomised; acceptance order and count are scoreboarded.
module tb_pipelined_addsub;
  import addsub_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin, mode;
  logic [15:0] a, b;

  logic        in_ready4, out_valid4, cout4, of4;
  logic [15:0] sum4;
  logic        in_ready1, out_valid1, cout1, of1;
  logic [15:0] sum1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b),
    .cin(cin), .mode(mode), .out_valid(out_valid4), .out_ready(out_ready),
    .sum(sum4), .cout(cout4), .of(of4)
  );

  pipelined_addsub #(.WIDTH(16), .BLOCK(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .cin(cin), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .of(of1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Result {of, cout, sum} from plain integer arithmetic on unsigned and signed views.
  function automatic logic [17:0] ref_calc(input logic [15:0] x, input logic [15:0] y,
                                           input logic ci, input logic md);
    int ux, uy, sx, sy, c, ur, sr;
    logic [15:0] s;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    c  = ci ? 1 : 0;
    if (md == MODE_ADD) begin
      ur = ux + uy + c;
      sr = sx + sy + c;
      co = (ur > 65535);
    end else begin
      ur = ux - uy - c;
      sr = sx - sy - c;
      co = (ur >= 0);
    end
    s  = ur[15:0];
    ov = (sr > 32767) || (sr < -32768);
`ifdef SATURATE_EN
    if (ov) s = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {ov, co, s};
  endfunction

  function automatic logic [15:0] pick16();
    logic [15:0] r;
    case ($urandom_range(0, 5))
      0:       r = 16'h0000;
      1:       r = 16'h7FFF;
      2:       r = 16'h8000;
      3:       r = 16'hFFFF;
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  // Reference pipelines: a beat enters when the consumer side is free, leaves after the build's depth.
  bit          mv4 [4];
  logic [17:0] mr4 [4];
  bit          mv1;
  logic [17:0] mr1;
  int acc4 = 0, acc1 = 0, disc4 = 0, disc1 = 0, emit4 = 0, emit1 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (mv4[i]) disc4++;
        mv4[i] = 1'b0;
      end
      if (mv1) disc1++;
      mv1 = 1'b0;
    end else begin
      if (out_ready || !mv4[3]) begin
        for (int i = 3; i > 0; i--) begin
          mv4[i] = mv4[i-1];
          mr4[i] = mr4[i-1];
        end
        mv4[0] = in_valid;
        mr4[0] = ref_calc(a, b, cin, mode);
        if (in_valid) acc4++;
      end
      if (out_ready || !mv1) begin
        mv1 = in_valid;
        mr1 = ref_calc(a, b, cin, mode);
        if (in_valid) acc1++;
      end
    end
  end

  // Compare every cycle, mid-period, against the reference pipelines.
  always @(negedge clk) begin
    chk("in_ready4", 32'(in_ready4), 32'(out_ready || !mv4[3]));
    chk("out_valid4", 32'(out_valid4), 32'(mv4[3]));
    if (mv4[3]) chk("result4", 32'({of4, cout4, sum4}), 32'(mr4[3]));
    chk("in_ready1", 32'(in_ready1), 32'(out_ready || !mv1));
    chk("out_valid1", 32'(out_valid1), 32'(mv1));
    if (mv1) chk("result1", 32'({of1, cout1, sum1}), 32'(mr1));
    if (out_valid4 && out_ready) emit4++;
    if (out_valid1 && out_ready) emit1++;
  end

  // Directed vectors with hand-computed results.
`ifdef SATURATE_EN
  localparam logic [15:0] S0 = 16'h7FFF, S2 = 16'h8000, S4 = 16'h8000;
`else
  localparam logic [15:0] S0 = 16'h8000, S2 = 16'h7FFE, S4 = 16'h7FFF;
`endif
  logic [15:0] va  [6] = '{16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF, 16'h8000, 16'h1234};
  logic [15:0] vb  [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h1111};
  logic        vc  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        vm  [6] = '{MODE_ADD, MODE_SUB, MODE_SUB, MODE_ADD, MODE_SUB, MODE_ADD};
  logic [17:0] vx  [6] = '{{2'b10, S0}, {2'b00, 16'hFFFF}, {2'b11, S2},
                           {2'b01, 16'h0001}, {2'b11, S4}, {2'b00, 16'h2345}};

  // Idle pipe, out_ready=1, called just after a rising edge.
  task automatic send_one(input string nm, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic md, input logic [17:0] exp);
    a = x; b = y; cin = ci; mode = md; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, " 1stage valid"}, 32'(out_valid1), 32'd1);
    chk({nm, " 1stage"}, 32'({of1, cout1, sum1}), 32'(exp));
    repeat (2) @(posedge clk);
    #1;
    chk({nm, " early valid"}, 32'(out_valid4), 32'd0);
    @(posedge clk); #1;
    chk({nm, " valid"}, 32'(out_valid4), 32'd1);
    chk({nm, " result"}, 32'({of4, cout4, sum4}), 32'(exp));
  endtask

  int  sent, cyc;
  bit  acc, saw_drop, hold, stale, drained;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; mode = MODE_ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid4", 32'(out_valid4), 32'd0);
    chk("reset in_ready4", 32'(in_ready4), 32'd1);
    chk("reset outputs4", 32'({of4, cout4, sum4}), 32'd0);
    chk("reset out_valid1", 32'(out_valid1), 32'd0);
    chk("reset outputs1", 32'({of1, cout1, sum1}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      chk($sformatf("model pin %0d", i), 32'(ref_calc(va[i], vb[i], vc[i], vm[i])), 32'(vx[i]));
      send_one($sformatf("directed %0d", i), va[i], vb[i], vc[i], vm[i], vx[i]);
    end

    // Eight back-to-back beats with a three-cycle consumer stall in the middle.
    sent = 0; cyc = 0; saw_drop = 1'b0;
    a = pick16(); b = pick16(); cin = 1'($urandom); mode = 1'($urandom); in_valid = 1'b1;
    while (sent < 8 && cyc < 64) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      @(negedge clk);
      acc = in_ready4;
      if (out_valid4 && !out_ready && !in_ready4) saw_drop = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        a = pick16(); b = pick16(); cin = 1'($urandom); mode = 1'($urandom);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream beats accepted", 32'(sent), 32'd8);
    chk("stall drops in_ready", 32'(saw_drop), 32'd1);
    repeat (6) @(posedge clk);
    #1;

    // Reset with beats in flight: nothing from before may surface afterwards.
    for (int i = 0; i < 5; i++) begin
      a = pick16(); b = pick16(); cin = 1'($urandom); mode = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre-reset out_valid", 32'(out_valid4), 32'd1);
    rst = 1'b1;
    #1;
    chk("async reset out_valid4", 32'(out_valid4), 32'd0);
    chk("async reset in_ready4", 32'(in_ready4), 32'd1);
    chk("async reset out_valid1", 32'(out_valid1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid4 || out_valid1) stale = 1'b1;
    end
    chk("no stale after reset", 32'(stale), 32'd0);
    send_one("post reset", 16'h1234, 16'h1111, 1'b0, MODE_ADD, {2'b00, 16'h2345});

    // Random traffic with random consumer stalls; inputs held until accepted.
    hold = 1'b0;
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 1));
        a = pick16(); b = pick16(); cin = 1'($urandom); mode = 1'($urandom);
      end
      @(negedge clk);
      hold = in_valid && !in_ready4;
      @(posedge clk); #1;
    end

    in_valid = 1'b0; out_ready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      @(posedge clk); #1;
      drained = !(mv4[0] || mv4[1] || mv4[2] || mv4[3] || mv1);
    end
    chk("drain within budget", 32'(drained), 32'd1);
    @(negedge clk); #1;
    chk("emitted count4", 32'(emit4), 32'(acc4 - disc4));
    chk("emitted count1", 32'(emit1), 32'(acc1 - disc1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

endmodule
